// File: rtl/serial_pkg.sv
// serial_pkg: shared constants, FSM state types and the divider helper for the
// serial UART core. Words are 16 bits and travel as two 8N1 frames, low byte first.
package serial_pkg;

  localparam int BIT_OS         = 16;
  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int WORD_W         = BITS_PER_BYTE * BYTES_PER_WORD;

  // Clocks per oversample tick, truncated.
  function automatic int calc_os_div(input int clkFreq, input int baud, input int os);
    return clkFreq / (baud * os);
  endfunction

  localparam int OS_DIV = calc_os_div(50_000_000, 115_200, BIT_OS);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_GAP} rx_state_t;

endpackage

// File: rtl/serial_uart_core_if.sv
// serial_uart_core_if: word-level TX request and RX result signals plus the two
// serial lines.
//   master: the client side (drives Send/DataIn and the RX line).
//   slave : the UART core.
interface serial_uart_core_if;
  logic                         Send;
  logic [serial_pkg::WORD_W-1:0] DataIn;
  logic                         Receive;
  logic                         Transmit;
  logic                         TxBusy;
  logic                         RxValid;
  logic [serial_pkg::WORD_W-1:0] RxData;
  logic                         RxFrameErr;

  modport master (output Send, DataIn, Receive,
                  input  Transmit, TxBusy, RxValid, RxData, RxFrameErr);
  modport slave  (input  Send, DataIn, Receive,
                  output Transmit, TxBusy, RxValid, RxData, RxFrameErr);
endinterface

// File: rtl/serial_tick_gen.sv
// serial_tick_gen: free-running tick generator.
//   Clock, Reset_n : system clock, async active-low reset
//   OsTick         : one-cycle pulse every OS_DIV clocks
//   BitTick        : one-cycle pulse on every OVERSAMPLE-th OsTick
module serial_tick_gen #(
  parameter int OS_DIV     = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic Clock,
  input  logic Reset_n,
  output logic OsTick,
  output logic BitTick
);
  localparam int DW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(OS_DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);

  logic [DW-1:0] divCnt;
  logic [OW-1:0] osCnt;

  assign OsTick  = (divCnt == DIV_LAST);
  assign BitTick = OsTick && (osCnt == OS_LAST);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      divCnt <= '0;
      osCnt  <= '0;
    end else begin
      divCnt <= OsTick ? '0 : divCnt + 1'b1;
      if (OsTick) osCnt <= (osCnt == OS_LAST) ? '0 : osCnt + 1'b1;
    end
  end
endmodule

// File: rtl/serial_uart_core.sv
// serial_uart_core: 16-bit-word UART, two 8N1 frames per word, low byte first.
//   Clock, Reset_n : system clock, async active-low reset
//   bus.Send/DataIn: level-sampled transmit request; word latched on acceptance
//   bus.Transmit   : registered TX line, idle high; bus.TxBusy while a word is out
//   bus.Receive    : async RX line; bus.RxData/RxValid hold the last good word
//   bus.RxFrameErr : one-cycle pulse on bad stop bit or inter-byte timeout
module serial_uart_core
  import serial_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int RX_TIMEOUT = 20
) (
  input logic              Clock,
  input logic              Reset_n,
  serial_uart_core_if.slave bus
);
  localparam int DIV      = calc_os_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int BIT_CLKS = DIV * OVERSAMPLE;
  localparam int TW       = $clog2(BIT_CLKS);
  localparam int CW       = $clog2(OVERSAMPLE);
  localparam int GW       = $clog2(RX_TIMEOUT + 1);
  localparam logic [TW-1:0] TX_BIT_LAST = TW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] OS_LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(RX_TIMEOUT - 1);
  localparam logic [2:0]    DBIT_LAST   = 3'(BITS_PER_BYTE - 1);

  logic osTick, bitTick;

  serial_tick_gen #(.OS_DIV(DIV), .OVERSAMPLE(OVERSAMPLE)) uTicks (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .OsTick  (osTick),
    .BitTick (bitTick)
  );

  // ---------------- transmitter ----------------
  // Bit timing uses a private clock counter rather than the free-running ticks,
  // so the start bit is a full bit time from the acceptance edge.
  tx_state_t         txState, txNext;
  logic [TW-1:0]     txCnt;
  logic [2:0]        txBit;
  logic              txHi;
  logic [WORD_W-1:0] txShift;
  logic              txLine;
  logic              bitDone;

  assign bitDone = (txCnt == TX_BIT_LAST);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) txState <= TX_IDLE;
    else          txState <= txNext;
  end

  always_comb begin
    txNext = txState;
    case (txState)
      TX_IDLE:  if (bus.Send) txNext = TX_START;
      TX_START: if (bitDone) txNext = TX_DATA;
      TX_DATA:  if (bitDone && txBit == DBIT_LAST) txNext = TX_STOP;
      TX_STOP:  if (bitDone) txNext = txHi ? TX_IDLE : TX_START;
      default:  txNext = TX_IDLE;
    endcase
  end

  // txShift is consumed from bit 0; after the low byte the high byte sits in [7:0].
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      txCnt   <= '0;
      txBit   <= '0;
      txHi    <= 1'b0;
      txShift <= '0;
      txLine  <= 1'b1;
    end else begin
      txCnt <= (txState == TX_IDLE || bitDone) ? '0 : txCnt + 1'b1;
      case (txState)
        TX_IDLE: if (bus.Send) begin
          txShift <= bus.DataIn;
          txHi    <= 1'b0;
          txLine  <= 1'b0;
        end
        TX_START: if (bitDone) begin
          txLine  <= txShift[0];
          txShift <= txShift >> 1;
          txBit   <= '0;
        end
        TX_DATA: if (bitDone) begin
          txBit <= txBit + 1'b1;
          if (txBit == DBIT_LAST) txLine <= 1'b1;
          else begin
            txLine  <= txShift[0];
            txShift <= txShift >> 1;
          end
        end
        TX_STOP: if (bitDone) begin
          txHi   <= 1'b1;
          txLine <= txHi;  // idle after the high byte, else straight into the next start
        end
        default: ;
      endcase
    end
  end

  assign bus.Transmit = txLine;
  assign bus.TxBusy   = (txState != TX_IDLE);

  // ---------------- receiver ----------------
  rx_state_t                  rxState, rxNext;
  logic                       rxS1, rxS2, rxPrev;
  logic                       fall;
  logic [CW-1:0]              rxCnt;
  logic [2:0]                 rxBit;
  logic                       rxHi;
  logic [BITS_PER_BYTE-1:0]   rxShift, rxLo;
  logic [GW-1:0]              gapCnt;
  logic [WORD_W-1:0]          rxData;
  logic                       rxValid, rxErr;

  // Edge seen between consecutive oversample points.
  assign fall = rxPrev && !rxS2;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) rxState <= RX_IDLE;
    else          rxState <= rxNext;
  end

  always_comb begin
    rxNext = rxState;
    if (osTick) begin
      case (rxState)
        RX_IDLE:  if (fall) rxNext = RX_START;
        RX_START: if (rxCnt == HALF_LAST) rxNext = rxS2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rxCnt == OS_LAST && rxBit == DBIT_LAST) rxNext = RX_STOP;
        RX_STOP:  if (rxCnt == OS_LAST) rxNext = (!rxS2 || rxHi) ? RX_IDLE : RX_GAP;
        RX_GAP:   if (fall) rxNext = RX_START;
                  else if (bitTick && gapCnt == GAP_LAST) rxNext = RX_IDLE;
        default:  rxNext = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rxS1    <= 1'b1;
      rxS2    <= 1'b1;
      rxPrev  <= 1'b1;
      rxCnt   <= '0;
      rxBit   <= '0;
      rxHi    <= 1'b0;
      rxShift <= '0;
      rxLo    <= '0;
      gapCnt  <= '0;
      rxData  <= '0;
      rxValid <= 1'b0;
      rxErr   <= 1'b0;
    end else begin
      rxS1  <= bus.Receive;
      rxS2  <= rxS1;
      rxErr <= 1'b0;
      if (osTick) begin
        rxPrev <= rxS2;
        case (rxState)
          RX_IDLE: begin
            rxCnt <= '0;
            rxHi  <= 1'b0;
          end
          RX_START: begin
            rxCnt <= rxCnt + 1'b1;
            if (rxNext == RX_DATA) begin
              rxCnt   <= '0;
              rxBit   <= '0;
              rxValid <= 1'b0;  // consumer sees a low period before each new word
            end
          end
          RX_DATA: begin
            rxCnt <= rxCnt + 1'b1;
            if (rxCnt == OS_LAST) begin
              rxShift <= {rxS2, rxShift[BITS_PER_BYTE-1:1]};
              rxBit   <= rxBit + 1'b1;
            end
          end
          RX_STOP: begin
            rxCnt <= rxCnt + 1'b1;
            if (rxCnt == OS_LAST) begin
              gapCnt <= '0;
              if (!rxS2) rxErr <= 1'b1;
              else if (!rxHi) begin
                rxLo <= rxShift;
                rxHi <= 1'b1;
              end else begin
                rxData  <= {rxShift, rxLo};
                rxValid <= 1'b1;
              end
            end
          end
          RX_GAP: begin
            if (rxNext == RX_IDLE) rxErr <= 1'b1;
            else if (bitTick) gapCnt <= gapCnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.RxData     = rxData;
  assign bus.RxValid    = rxValid;
  assign bus.RxFrameErr = rxErr;
endmodule

// File: tb/tb_serial_uart_core.sv
// Testbench for serial_uart_core: reset state, false start, stop-bit error,
// inter-byte timeout, a random directly-driven RX word, a table of loopback
// words (one with an ignored mid-word Send), and reset mid-transmission.
module tb_serial_uart_core;
  import serial_pkg::*;

  localparam int BITC = 432;   // clocks per bit at default parameters
  localparam int OSC  = 27;    // clocks per oversample tick

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  logic loop = 1'b0;
  logic rxDrive = 1'b1;

  serial_uart_core_if bus();
  assign bus.Receive = loop ? bus.Transmit : rxDrive;

  serial_uart_core dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  // ---------------- RX event recorder ----------------
  logic [15:0] gotWords[$];
  int   riseCnt = 0;
  int   errCnt = 0;
  int   errLenCur = 0;
  int   lastErrLen = 0;
  logic prevValid = 1'b0;

  always @(negedge Clock) begin
    if (bus.RxValid === 1'b1 && prevValid !== 1'b1) begin
      gotWords.push_back(bus.RxData);
      riseCnt++;
    end
    prevValid = bus.RxValid;
    if (bus.RxFrameErr === 1'b1) errLenCur++;
    else if (errLenCur > 0) begin
      errCnt++;
      lastErrLen = errLenCur;
      errLenCur = 0;
    end
  end

  // ---------------- checking ----------------
  int nChecks = 0;
  int nPass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Line level of bit i (0..19) of a word: two frames of start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [15:0] w, input int i);
    int pos;
    int byteIdx;
    pos = i % 10;
    byteIdx = i / 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[byteIdx * 8 + pos - 1];
  endfunction

  function automatic logic [15:0] last_word();
    if (gotWords.size() == 0) return 16'hxxxx;
    return gotWords[gotWords.size() - 1];
  endfunction

  // Sends one word and checks every clock of all 20 bits on the TX line.
  task automatic send_word(input logic [15:0] w, input bit pulseIgnore,
                           input bit expDrop, input int expBusy);
    int bad;
    int busyCnt;
    busyCnt = 0;
    @(negedge Clock);
    bus.Send = 1'b1;
    bus.DataIn = w;
    @(posedge Clock);
    #1 bus.Send = 1'b0;
    for (int b = 0; b < 20; b++) begin
      bad = 0;
      for (int c = 0; c < BITC; c++) begin
        @(negedge Clock);
        if (bus.Transmit !== frame_bit(w, b)) bad++;
        if (bus.TxBusy === 1'b1) busyCnt++;
        if (expDrop && b == 0 && c == 0) chk("rxvalid_hold_before_start", bus.RxValid, 1);
        if (expDrop && b == 2 && c == 0) chk("rxvalid_drop_at_start", bus.RxValid, 0);
        if (pulseIgnore && b == 5 && c == 100) begin
          bus.Send = 1'b1;
          bus.DataIn = 16'hBEEF;
        end
        if (pulseIgnore && b == 5 && c == 101) bus.Send = 1'b0;
      end
      chk($sformatf("tx_%04h_bit%0d_bad_clocks", w, b), bad, 0);
    end
    chk($sformatf("tx_%04h_busy_clocks", w), busyCnt, expBusy);
    @(negedge Clock);
    chk($sformatf("tx_%04h_busy_end", w), bus.TxBusy, 0);
    chk($sformatf("tx_%04h_line_idle", w), bus.Transmit, 1);
    if (pulseIgnore) begin
      repeat (5) @(negedge Clock);
      chk("ignored_send_not_queued", bus.TxBusy, 0);
    end
  endtask

  task automatic drive_bits(input logic v, input int nbits);
    rxDrive = v;
    repeat (nbits * BITC) @(negedge Clock);
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic stopv);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
    drive_bits(stopv, 1);
  endtask

  typedef struct {
    logic [15:0] word;
    bit          pulseIgnore;
    logic [15:0] expRx;
    int          expBusy;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int base;
    logic [7:0] lo;
    logic [7:0] hi;
    int g;

    vecs[0] = '{word: 16'h1234, pulseIgnore: 1'b1, expRx: 16'h1234, expBusy: 8640};
    vecs[1] = '{word: 16'hA55A, pulseIgnore: 1'b0, expRx: 16'hA55A, expBusy: 8640};
    vecs[2] = '{word: 16'h00FF, pulseIgnore: 1'b0, expRx: 16'h00FF, expBusy: 8640};

    bus.Send = 1'b0;
    bus.DataIn = '0;

    // reset state
    repeat (3) @(negedge Clock);
    chk("reset_transmit", bus.Transmit, 1);
    chk("reset_txbusy", bus.TxBusy, 0);
    chk("reset_rxvalid", bus.RxValid, 0);
    chk("reset_rxdata", bus.RxData, 0);
    chk("reset_frameerr", bus.RxFrameErr, 0);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clock);
    chk("idle_transmit", bus.Transmit, 1);

    // false start: 3 oversample ticks low
    rxDrive = 1'b0;
    repeat (3 * OSC) @(negedge Clock);
    rxDrive = 1'b1;
    repeat (40 * OSC) @(negedge Clock);
    chk("false_start_rxvalid", bus.RxValid, 0);
    chk("false_start_err_pulses", errCnt, 0);
    chk("false_start_rises", riseCnt, 0);

    // stop bit 0
    drive_byte(8'hC3, 1'b0);
    drive_bits(1'b1, 2);
    chk("stop_err_pulses", errCnt, 1);
    chk("stop_err_len", lastErrLen, 1);
    chk("stop_err_rxvalid", bus.RxValid, 0);

    // low byte only, then 25 bit times idle
    drive_byte(8'h5A, 1'b1);
    drive_bits(1'b1, 25);
    chk("timeout_err_pulses", errCnt, 2);
    chk("timeout_err_len", lastErrLen, 1);
    chk("timeout_rxvalid", bus.RxValid, 0);
    chk("timeout_rises", riseCnt, 0);

    // random word driven straight onto RX with a short random inter-byte gap
    lo = 8'($urandom);
    hi = 8'($urandom);
    g  = int'($urandom_range(4, 0));
    drive_byte(lo, 1'b1);
    drive_bits(1'b1, g);
    drive_byte(hi, 1'b1);
    drive_bits(1'b1, 1);
    chk("rand_rx_word", last_word(), {hi, lo});
    chk("rand_rx_rises", riseCnt, 1);
    chk("rand_rx_valid", bus.RxValid, 1);
    chk("rand_rx_no_err", errCnt, 2);

    // loopback table
    loop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      base = riseCnt;
      send_word(vecs[i].word, vecs[i].pulseIgnore, 1'b1, vecs[i].expBusy);
      chk($sformatf("loop_rx_word%0d", i), last_word(), vecs[i].expRx);
      chk($sformatf("loop_rx_rise%0d", i), riseCnt, base + 1);
    end
    chk("loop_no_frame_err", errCnt, 2);

    // reset in the middle of a start bit
    @(negedge Clock);
    bus.Send = 1'b1;
    bus.DataIn = 16'hC0DE;
    @(posedge Clock);
    #1 bus.Send = 1'b0;
    repeat (200) @(negedge Clock);
    chk("mid_tx_start_low", bus.Transmit, 0);
    chk("mid_tx_busy", bus.TxBusy, 1);
    Reset_n = 1'b0;
    #1;
    chk("abort_transmit_high", bus.Transmit, 1);
    chk("abort_txbusy_low", bus.TxBusy, 0);
    repeat (5) @(negedge Clock);
    Reset_n = 1'b1;
    chk("abort_rxvalid", bus.RxValid, 0);
    chk("abort_rxdata", bus.RxData, 0);
    repeat (5) @(negedge Clock);
    base = riseCnt;
    send_word(16'h0F5A, 1'b0, 1'b0, 8640);
    chk("post_reset_rx_word", last_word(), 16'h0F5A);
    chk("post_reset_rx_rise", riseCnt, base + 1);
    chk("post_reset_no_err", errCnt, 2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
